// File: rtl/vit_pkg.sv
// Shared ViT image/patch geometry, pixel format and depatchifier state encoding.
package vit_pkg;

  localparam int CHANNEL_SIZE      = 8;
  localparam int NUM_CHANNELS      = 3;
  localparam int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS;
  localparam int IMG_WIDTH         = 16;
  localparam int IMG_HEIGHT        = 16;
  localparam int PATCH_SIZE        = 4;
  localparam int PATCH_SIZE_LOG2   = 2;
  localparam int PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE;
  localparam int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE);
  localparam int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE;

  // Counter / coordinate widths derived from the geometry above
  localparam int PATCH_IDX_W = $clog2(TOTAL_NUM_PATCHES);
  localparam int POS_IDX_W   = $clog2(PATCH_VECTOR_SIZE);
  localparam int ROW_W       = $clog2(IMG_HEIGHT);
  localparam int COL_W       = $clog2(IMG_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/patch_addr_map.sv
// Maps a (patch index, position within patch) pair onto image (row, col).
// Purely combinational so the patchifier side can share it.
module patch_addr_map
  import vit_pkg::*;
(
  input  logic [PATCH_IDX_W-1:0] patch_index,
  input  logic [POS_IDX_W-1:0]   position_index,
  output logic [ROW_W-1:0]       row,
  output logic [COL_W-1:0]       col
);

  // Patch grid origin plus the offset of the pixel inside its patch
  always_comb begin
    row = ROW_W'((int'(patch_index) / PATCHES_IN_ROW) * PATCH_SIZE
                 + (int'(position_index) >> PATCH_SIZE_LOG2));
    col = COL_W'((int'(patch_index) % PATCHES_IN_ROW) * PATCH_SIZE
                 + (int'(position_index) & (PATCH_SIZE - 1)));
  end

endmodule

// File: rtl/depatchifier.sv
// Rebuilds a raster-order image from a patch-major pixel stream: fills a full
// frame buffer, then drains it row by row.
module depatchifier
  import vit_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_pixel,
  output logic                   out_last,
  output logic [1:0]             state,
  output logic                   frame_error
);

  localparam logic [PATCH_IDX_W-1:0] P_LAST = PATCH_IDX_W'(TOTAL_NUM_PATCHES - 1);
  localparam logic [POS_IDX_W-1:0]   Q_LAST = POS_IDX_W'(PATCH_VECTOR_SIZE - 1);
  localparam logic [ROW_W-1:0]       R_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0]       C_LAST = COL_W'(IMG_WIDTH - 1);

  state_t cur_state, nxt_state;

  logic [PATCH_IDX_W-1:0] p;
  logic [POS_IDX_W-1:0]   q;
  logic [ROW_W-1:0]       r;
  logic [COL_W-1:0]       c;
  logic [ROW_W-1:0]       wr_row;
  logic [COL_W-1:0]       wr_col;

  logic [PIXEL_WIDTH-1:0] img [IMG_HEIGHT][IMG_WIDTH];

  logic fill_fire, out_fire, final_pixel;

  assign fill_fire   = in_ready && in_valid;
  assign out_fire    = out_valid && out_ready;
  assign final_pixel = (p == P_LAST) && (q == Q_LAST);
  assign state       = cur_state;
  assign out_pixel   = img[r][c];

  patch_addr_map u_addr_map (
    .patch_index    (p),
    .position_index (q),
    .row            (wr_row),
    .col            (wr_col)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= nxt_state;
  end

  // Next-state logic; handshake outputs depend on the registered state only
  always_comb begin
    nxt_state = cur_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (cur_state)
      IDLE: begin
        if (en) nxt_state = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (fill_fire && final_pixel) nxt_state = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (r == R_LAST) && (c == C_LAST);
        if (out_fire && (r == R_LAST) && (c == C_LAST)) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Patch/position counters walk the patch-major input order
  always_ff @(posedge clk) begin
    if (reset) begin
      p <= '0;
      q <= '0;
    end else if (fill_fire) begin
      if (q == Q_LAST) begin
        q <= '0;
        p <= final_pixel ? '0 : p + 1'b1;
      end else begin
        q <= q + 1'b1;
      end
    end
  end

  // Raster counters walk the output order
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= '0;
      c <= '0;
    end else if (out_fire) begin
      if (c == C_LAST) begin
        c <= '0;
        r <= (r == R_LAST) ? '0 : r + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
    end
  end

  // Frame buffer write; contents are intentionally not cleared by reset
  always_ff @(posedge clk) begin
    if (fill_fire) img[wr_row][wr_col] <= in_pixel;
  end

  // Sticky framing error: in_last must coincide exactly with the final pixel
  always_ff @(posedge clk) begin
    if (reset)                                      frame_error <= 1'b0;
    else if (fill_fire && (in_last != final_pixel)) frame_error <= 1'b1;
  end

endmodule

// File: tb/tb_depatchifier.sv
// Randomized self-checking bench for depatchifier with a patch-grid reference model.
module tb_depatchifier;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pixel;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_pixel;
  logic        out_last;
  logic [1:0]  state;
  logic        frame_error;

  int compared   = 0;
  int mismatched = 0;
  bit exp_err    = 1'b0;

  depatchifier dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pixel    (in_pixel),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pixel   (out_pixel),
    .out_last    (out_last),
    .state       (state),
    .frame_error (frame_error)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Raster pixel k lives in 4x4 patch (r/4, c/4) at offset (r%4, c%4) of the input stream
  function automatic logic [23:0] expPixel(input logic [23:0] base, input int k);
    int rr, cc, stream_idx;
    rr = k / 16;
    cc = k % 16;
    stream_idx = ((rr / 4) * 4 + cc / 4) * 16 + (rr % 4) * 4 + (cc % 4);
    return base + 24'(stream_idx);
  endfunction

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; en = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_frame_error", 32'(frame_error), 32'd0);
    reset = 1'b0;
  endtask

  // One frame; stall enables random valid/ready/en, err_at flags in_last early,
  // drop_last withholds it on the final pixel, abort_at stops after that many inputs
  task automatic applyStimulus(input logic [23:0] base, input bit stall,
                               input int err_at, input bit drop_last, input int abort_at);
    int  mphase = 0;
    int  idx    = 0;
    int  k      = 0;
    bit  done   = 1'b0;
    bit  in_hs, out_hs;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      en        = (mphase == 0) ? 1'b1 : (stall ? 1'($urandom % 2) : 1'b0);
      in_valid  = stall ? 1'($urandom % 2) : 1'b1;
      in_pixel  = (idx < 256) ? base + 24'(idx) : 24'($urandom);
      in_last   = (idx == 255) ? !drop_last : (idx == err_at);
      out_ready = stall ? 1'($urandom % 2) : 1'b1;
      #1;
      checkOutput("state", 32'(state), 32'(mphase));
      checkOutput("in_ready", 32'(in_ready), 32'(mphase == 1));
      checkOutput("out_valid", 32'(out_valid), 32'(mphase == 2));
      checkOutput("frame_error", 32'(frame_error), 32'(exp_err));
      if (mphase == 2) begin
        checkOutput($sformatf("pixel[%0d]", k), 32'(out_pixel), 32'(expPixel(base, k)));
        checkOutput($sformatf("out_last[%0d]", k), 32'(out_last), 32'(k == 255));
      end
      in_hs  = in_valid && (mphase == 1);
      out_hs = out_ready && (mphase == 2);
      if (mphase == 0 && en) mphase = 1;
      if (in_hs) begin
        if (in_last != (idx == 255)) exp_err = 1'b1;
        idx++;
        if (idx == 256) mphase = 2;
        if (idx == abort_at) begin
          done = 1'b1;
          break;
        end
      end
      if (out_hs) begin
        k++;
        if (k == 256) begin
          done = 1'b1;
          break;
        end
      end
    end
    if (!done) checkOutput("frame_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; in_valid = 1'b0; in_pixel = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    doReset();

    // in_valid while idle must not be accepted nor start a frame
    @(negedge clk);
    in_valid = 1'b1; in_pixel = 24'hABCDEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
      checkOutput("idle_state", 32'(state), 32'd0);
    end

    $display("[TB] clean frame");
    applyStimulus(24'd0, 1'b0, -1, 1'b0, -1);
    $display("[TB] back-to-back frame");
    applyStimulus(24'd1000, 1'b0, -1, 1'b0, -1);
    $display("[TB] stalled frames");
    applyStimulus(24'($urandom), 1'b1, -1, 1'b0, -1);
    applyStimulus(24'($urandom), 1'b1, -1, 1'b0, -1);

    $display("[TB] early in_last");
    applyStimulus(24'd0, 1'b0, 100, 1'b0, -1);
    checkOutput("early_last_err", 32'(frame_error), 32'd1);
    doReset();

    $display("[TB] missing in_last");
    applyStimulus(24'd5000, 1'b1, -1, 1'b1, -1);
    checkOutput("missing_last_err", 32'(frame_error), 32'd1);
    doReset();

    $display("[TB] reset mid-fill");
    applyStimulus(24'd77, 1'b1, -1, 1'b0, 130);
    doReset();
    applyStimulus(24'($urandom), 1'b1, -1, 1'b0, -1);

    @(negedge clk);
    #1;
    checkOutput("final_state", 32'(state), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
